// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Decouples the core's store path from memory write latency. Each store
// (stAddr, dOut) issued with stWr is queued in a DEPTH-entry FIFO. Entries
// are drained in issue order, one at a time, over a memReq/memAck handshake.
//
// Optional feature (compile-time macro STORE_FWD_EN): store-to-load
// forwarding. Adds ldAddr, fwdHit and fwdData. fwdData is the data of the
// youngest queued entry, including the in-flight head, whose address
// matches ldAddr. When the macro is undefined, these ports and the
// comparators do not exist.
//
// Ports:
//   clk      in   system clock, rising-edge active
//   reset    in   asynchronous active-high reset
//   dOut     in   store data, DW bits
//   stAddr   in   store address, AW bits, qualified by stWr
//   stWr     in   store issue strobe
//   sbFull   out  DEPTH entries held; the core must stall stores
//   sbEmpty  out  nothing queued and nothing in flight
//   sbOvf    out  sticky: a store was dropped because the buffer was full
//   memReq   out  memory write request
//   memAddr  out  write address, stable while memReq=1
//   memData  out  write data, stable while memReq=1
//   memAck   in   memory accepts the current write at the rising edge
//   ldAddr   in   (STORE_FWD_EN) load address to look up
//   fwdHit   out  (STORE_FWD_EN) some queued entry matches ldAddr
//   fwdData  out  (STORE_FWD_EN) data of the youngest match, 0 when no match
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] dOut,
    input  logic [AW-1:0] stAddr,
    input  logic          stWr,
    output logic          sbFull,
    output logic          sbEmpty,
    output logic          sbOvf,
    output logic          memReq,
    output logic [AW-1:0] memAddr,
    output logic [DW-1:0] memData,
    input  logic          memAck
`ifdef STORE_FWD_EN
    ,
    input  logic [AW-1:0] ldAddr,
    output logic          fwdHit,
    output logic [DW-1:0] fwdData
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t        state;
    state_t        stateNext;

    // Entry storage is not reset. Its contents are only meaningful below count.
    logic [AW-1:0] addrMem [DEPTH];
    logic [DW-1:0] dataMem [DEPTH];

    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] nextRdPtr;
    logic [CW-1:0] count;

    logic          pushEn;
    logic          popEn;
    logic          reqNext;
    logic          loadHead;
    logic [AW-1:0] headAddrNext;
    logic [DW-1:0] headDataNext;

    assign sbFull    = (count == FULL_CNT);
    assign sbEmpty   = (count == '0);

    // Fullness is judged on the registered count. A pop on the same edge
    // therefore never makes room for a push.
    assign pushEn    = stWr && !sbFull;
    assign popEn     = (state == REQ) && memAck;
    assign nextRdPtr = rdPtr + PW'(1);

    // -------------------------------------------------------------------------
    // Drain FSM: next state and head-register load selection
    // -------------------------------------------------------------------------
    always_comb begin
        stateNext    = state;
        reqNext      = memReq;
        loadHead     = 1'b0;
        headAddrNext = addrMem[rdPtr];
        headDataNext = dataMem[rdPtr];
        case (state)
            IDLE: begin
                if (count != '0) begin
                    stateNext = REQ;
                    reqNext   = 1'b1;
                    loadHead  = 1'b1;
                end
            end
            REQ: begin
                if (memAck) begin
                    if (count > CW'(1)) begin
                        // The next older entry is already stored.
                        loadHead     = 1'b1;
                        headAddrNext = addrMem[nextRdPtr];
                        headDataNext = dataMem[nextRdPtr];
                    end else if (pushEn) begin
                        // The last entry leaves while a new one arrives. The
                        // new head is the store being written on this edge,
                        // so take it straight from the inputs to avoid a bubble.
                        loadHead     = 1'b1;
                        headAddrNext = stAddr;
                        headDataNext = dOut;
                    end else begin
                        stateNext = IDLE;
                        reqNext   = 1'b0;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                reqNext   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control and request registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            memReq  <= 1'b0;
            memAddr <= '0;
            memData <= '0;
            sbOvf   <= 1'b0;
        end else begin
            state  <= stateNext;
            memReq <= reqNext;
            if (loadHead) begin
                memAddr <= headAddrNext;
                memData <= headDataNext;
            end
            if (pushEn) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (popEn) begin
                rdPtr <= nextRdPtr;
            end
            if (pushEn && !popEn) begin
                count <= count + CW'(1);
            end else if (!pushEn && popEn) begin
                count <= count - CW'(1);
            end
            if (stWr && sbFull) begin
                sbOvf <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage write port
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (pushEn) begin
            addrMem[wrPtr] <= stAddr;
            dataMem[wrPtr] <= dOut;
        end
    end

`ifdef STORE_FWD_EN
    // -------------------------------------------------------------------------
    // Store-to-load forwarding. The scan runs from oldest (rdPtr) to youngest.
    // Each later match overrides an earlier one, so the youngest match wins.
    // -------------------------------------------------------------------------
    logic [PW-1:0] scanIdx;

    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        scanIdx = rdPtr;
        for (int k = 0; k < DEPTH; k++) begin
            scanIdx = rdPtr + PW'(k);
            if ((CW'(k) < count) && (addrMem[scanIdx] == ldAddr)) begin
                fwdHit  = 1'b1;
                fwdData = dataMem[scanIdx];
            end
        end
    end
`endif

endmodule
